// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with a single-outstanding req/ack data bus.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN: trap misaligned half/word accesses
// instead of forcing them to natural alignment.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [1:0]  mem_len,
    input  logic        mem_uns,
    input  logic        reg_w,
    input  logic [31:0] reg_data,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_w,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic [31:0] exc_addr
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [1:0]  lo_q;
    logic [1:0]  len_q;
    logic        uns_q;
    logic        reg_w_q;
    logic [4:0]  rd_q;
    logic        is_mem;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [31:0] al_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] shifted;
    logic [31:0] ld_data;
    assign in_ready = (state == IDLE);
    // Decode the incoming access and build aligned address, lane-replicated data and byte enables.
    always_comb begin
        is_mem   = mem_w | mem_r;
        is_byte  = (mem_len == 2'd0);
        is_half  = (mem_len == 2'd1);
        is_word  = mem_len[1];
        al_addr  = is_word ? {mem_addr[31:2], 2'b00} : is_half ? {mem_addr[31:1], 1'b0} : mem_addr;
        st_wdata = is_byte ? {4{mem_data[7:0]}} : is_half ? {2{mem_data[15:0]}} : mem_data;
        st_be    = is_byte ? 4'b0001 << al_addr[1:0] : is_half ? (al_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    // Extract the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        shifted = dmem_rdata >> {lo_q, 3'b000};
        ld_data = (len_q == 2'd0) ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                  (len_q == 2'd1) ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : dmem_rdata;
    end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic mis;
    assign mis = is_mem & ((is_half & mem_addr[0]) | (is_word & |mem_addr[1:0]));
`else
    assign exc_misalign = 1'b0;
    assign exc_addr     = 32'd0;
`endif
    // Stage FSM: pass-through in IDLE, hold the bus request in REQ until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            wb_valid   <= 1'b0;
            wb_reg_w   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            lo_q       <= 2'd0;
            len_q      <= 2'd0;
            uns_q      <= 1'b0;
            reg_w_q    <= 1'b0;
            rd_q       <= 5'd0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            exc_misalign <= 1'b0;
            exc_addr     <= 32'd0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            exc_misalign <= 1'b0;
`endif
            if (state == IDLE) begin
                if (in_valid) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                    if (mis) begin
                        exc_misalign <= 1'b1;
                        exc_addr     <= mem_addr;
                    end else
`endif
                    if (is_mem) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_w;
                        dmem_addr  <= {al_addr[31:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= mem_w ? st_be : 4'b0000;
                        lo_q       <= al_addr[1:0];
                        len_q      <= mem_len;
                        uns_q      <= mem_uns;
                        reg_w_q    <= reg_w;
                        rd_q       <= rd;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_reg_w <= reg_w;
                        wb_rd    <= rd;
                        wb_data  <= reg_data;
                    end
                end
            end else if (dmem_ack) begin
                state    <= IDLE;
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                dmem_be  <= 4'd0;
                wb_valid <= 1'b1;
                wb_reg_w <= ~dmem_we & reg_w_q;
                wb_rd    <= rd_q;
                wb_data  <= dmem_we ? 32'd0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus scoreboard for the memory-access stage.
module tb_mem_stage;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0, in_ready;
    logic mem_w = 0, mem_r = 0, mem_uns = 0, reg_w = 0;
    logic [31:0] mem_addr = 0, mem_data = 0, reg_data = 0;
    logic [1:0] mem_len = 0;
    logic [4:0] rd = 0;
    logic dmem_req, dmem_we, dmem_ack = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic [3:0] dmem_be;
    logic wb_valid, wb_reg_w, exc_misalign;
    logic [4:0] wb_rd;
    logic [31:0] wb_data, exc_addr;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_w(mem_w), .mem_r(mem_r), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_len(mem_len), .mem_uns(mem_uns), .reg_w(reg_w), .reg_data(reg_data), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_w(wb_reg_w), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_addr(exc_addr)
    );

    typedef struct {
        logic w, r, uns, rw;
        logic [31:0] addr, data, rdata, reg_data;
        logic [1:0] len;
        logic [4:0] rd;
        int waits;
        logic [31:0] e_addr, e_wdata, e_data;
        logic [3:0] e_be;
        logic e_reg_w;
    } vec_t;

    typedef struct {
        logic rw;
        logic [4:0] rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_reg_w", 32'(wb_reg_w), 32'(e.rw));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic drive(input vec_t v);
        in_valid = 1; mem_w = v.w; mem_r = v.r; mem_addr = v.addr; mem_data = v.data;
        mem_len = v.len; mem_uns = v.uns; reg_w = v.rw; reg_data = v.reg_data; rd = v.rd;
    endtask

    task automatic run_vec(input vec_t v);
        wb_t e;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        drive(v);
        e.rw = v.e_reg_w; e.rd = v.rd; e.data = v.e_data;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 0;
        if (v.w | v.r) begin
            for (int j = 0; j <= v.waits; j++) begin
                chk("dmem_req", 32'(dmem_req), 32'd1);
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                chk("dmem_addr", dmem_addr, v.e_addr);
                chk("dmem_be", 32'(dmem_be), 32'(v.e_be));
                chk("dmem_we", 32'(dmem_we), 32'(v.w));
                if (v.w) chk("dmem_wdata", dmem_wdata, v.e_wdata);
                if (j == v.waits) begin
                    dmem_ack = 1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
            end
            dmem_ack = 0;
            chk("dmem_req_drop", 32'(dmem_req), 32'd0);
        end
    endtask

    vec_t tbl[10];

    initial begin
        //            w  r  uns rw addr          data          rdata         reg_data  len rd waits e_addr        e_wdata       e_data        e_be     e_reg_w
        tbl[0] = '{1'b1,1'b0,1'b0,1'b1,32'h1003,32'hAABBCCDD,32'h0,32'h0,2'd0,5'd3,2,32'h1000,32'hDDDDDDDD,32'h0,4'b1000,1'b0};
        tbl[1] = '{1'b0,1'b1,1'b0,1'b1,32'h2001,32'h0,32'h00008000,32'h0,2'd0,5'd7,0,32'h2000,32'h0,32'hFFFFFF80,4'b0000,1'b1};
        tbl[2] = '{1'b0,1'b1,1'b1,1'b1,32'h2001,32'h0,32'h00008000,32'h0,2'd0,5'd8,0,32'h2000,32'h0,32'h00000080,4'b0000,1'b1};
        tbl[3] = '{1'b0,1'b1,1'b0,1'b1,32'h2002,32'h0,32'h80010000,32'h0,2'd1,5'd9,1,32'h2000,32'h0,32'hFFFF8001,4'b0000,1'b1};
        tbl[4] = '{1'b0,1'b1,1'b1,1'b1,32'h2002,32'h0,32'h80010000,32'h0,2'd1,5'd10,0,32'h2000,32'h0,32'h00008001,4'b0000,1'b1};
        tbl[5] = '{1'b1,1'b0,1'b0,1'b1,32'h1002,32'h11223344,32'h0,32'h0,2'd1,5'd11,1,32'h1000,32'h33443344,32'h0,4'b1100,1'b0};
        tbl[6] = '{1'b1,1'b0,1'b0,1'b0,32'h100C,32'hCAFEBABE,32'h0,32'h0,2'd3,5'd12,0,32'h100C,32'hCAFEBABE,32'h0,4'b1111,1'b0};
        tbl[7] = '{1'b0,1'b1,1'b0,1'b1,32'h2004,32'h0,32'h12345678,32'h0,2'd2,5'd13,3,32'h2004,32'h0,32'h12345678,4'b0000,1'b1};
        tbl[8] = '{1'b0,1'b1,1'b0,1'b1,32'h2003,32'h0,32'h7F000000,32'h0,2'd0,5'd14,0,32'h2000,32'h0,32'h0000007F,4'b0000,1'b1};
        tbl[9] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,32'h0,32'hDEADBEEF,2'd0,5'd15,0,32'h0,32'h0,32'hDEADBEEF,4'b0000,1'b1};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", 32'(exc_misalign), 32'd0);
        rst = 0;

        begin
            wb_t e;
            e.rw = 1; e.rd = 5; e.data = 32'h12345678;
            @(negedge clk);
            in_valid = 1; mem_w = 0; mem_r = 0; reg_w = 1; rd = 5; reg_data = 32'h12345678;
            for (int i = 0; i < 3; i++) begin
                chk("pt_in_ready", 32'(in_ready), 32'd1);
                if (i > 0) chk("pt_wb_valid", 32'(wb_valid), 32'd1);
                sb.push_back(e);
                @(negedge clk);
            end
            in_valid = 0;
            chk("pt_wb_valid_last", 32'(wb_valid), 32'd1);
            @(negedge clk);
            chk("pt_wb_valid_end", 32'(wb_valid), 32'd0);
        end

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        begin
            vec_t v;
            v = '{1'b0,1'b1,1'b0,1'b1,32'h3002,32'h0,32'hA1B2C3D4,32'h0,2'd2,5'd20,1,32'h3000,32'h0,32'hA1B2C3D4,4'b0000,1'b1};
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            @(negedge clk);
            drive(v);
            @(negedge clk);
            in_valid = 0;
            chk("mis_exc", 32'(exc_misalign), 32'd1);
            chk("mis_addr", exc_addr, 32'h3002);
            chk("mis_no_req", 32'(dmem_req), 32'd0);
            chk("mis_in_ready", 32'(in_ready), 32'd1);
            chk("mis_no_wb", 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk("mis_pulse_end", 32'(exc_misalign), 32'd0);
            chk("mis_still_no_req", 32'(dmem_req), 32'd0);
`else
            run_vec(v);
            chk("no_exc", 32'(exc_misalign), 32'd0);
`endif
        end

        @(negedge clk);
        mem_w = 0; mem_r = 1; mem_addr = 32'h2000; mem_len = 2'd2; reg_w = 1; rd = 21; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        chk("abort_req_up", 32'(dmem_req), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        dmem_ack = 1;
        dmem_rdata = 32'h55555555;
        chk("abort_req_down", 32'(dmem_req), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        dmem_ack = 0;
        chk("late_ack_no_wb", 32'(wb_valid), 32'd0);
        chk("late_ack_no_req", 32'(dmem_req), 32'd0);

        @(negedge clk);
        mem_w = 1; mem_addr = 32'h40; mem_len = 2'd2; in_valid = 1; rst = 1;
        @(negedge clk);
        in_valid = 0; rst = 0;
        chk("rst_wins_req", 32'(dmem_req), 32'd0);
        chk("rst_wins_ready", 32'(in_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I core, directly downstream of the execute stage. Consumes execute's memory/writeback outputs, drives a single-outstanding request/acknowledge data-memory bus with byte-lane alignment, extracts and sign/zero-extends load data, and presents one result per instruction to register writeback. Non-memory instructions pass through in one cycle. Upstream is stalled while a memory access is in flight.

## Interface
Parameters: none.

One clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute result valid this cycle
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- mem_w  in  1  store instruction
- mem_r  in  1  load instruction
- mem_addr  in  32  effective byte address
- mem_data  in  32  store data (rs2 value)
- mem_len  in  2  0 byte, 1 half, 2 word, 3 treated as word
- mem_uns  in  1  load zero-extends when 1
- reg_w  in  1  instruction writes rd
- reg_data  in  32  ALU/link result for non-load instructions
- rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 write, 0 read
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (0000 on reads)
- dmem_ack  in  1  request completed; rdata valid same cycle on reads
- dmem_rdata  in  32  read data word
- wb_valid  out  1  one-cycle result pulse to writeback
- wb_reg_w  out  1  write rd
- wb_rd  out  5  destination register
- wb_data  out  32  write data
- exc_misalign  out  1  misaligned-access pulse (macro only; else tied 0)
- exc_addr  out  32  faulting address (macro only; else tied 0)

## Operation
- FSM states: IDLE, REQ. in_ready = (state == IDLE).
- IDLE, accept, no mem_r/mem_w: next cycle wb_valid=1, wb_reg_w=reg_w, wb_rd=rd, wb_data=reg_data; stay IDLE.
- IDLE, accept, mem_w or mem_r (mem_w wins if both): latch addr/data/len/uns/rd/reg_w; go REQ.
- REQ: dmem_req=1; addr, we, wdata, be held stable until dmem_ack sampled high. On ack: go IDLE; next cycle wb_valid=1.
- Store lanes: byte wdata={4{d[7:0]}}, be=0001<<addr[1:0]; half wdata={2{d[15:0]}}, be=addr[1]?1100:0011; word be=1111.
- Load: shifted=rdata>>(8*addr[1:0]); byte/half take low 8/16 bits, sign-extend from bit 7/15 unless mem_uns; word unmodified. wb_reg_w=reg_w, wb_data=extracted value.
- Store result: wb_valid=1, wb_reg_w=0, wb_data=0.
- dmem_ack while dmem_req=0 is ignored.

## Timing
- Reset values: state IDLE, in_ready 1, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, dmem_be 0, wb_valid 0, wb_reg_w 0, wb_rd 0, wb_data 0, exc_misalign 0, exc_addr 0.
- Pass-through latency 1 cycle; back-to-back every cycle.
- Memory op accepted at T: dmem_req from T+1; ack at T+1+k; wb_valid at T+2+k; in_ready high again at T+2+k (new accept allowed that cycle).
- Zero-wait ack (ack in first req cycle) supported.
- rst during REQ: dmem_req drops at that edge; no wb_valid for the aborted op; a late ack is ignored.
- rst overrides simultaneous accept.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is not issued; cycle after accept exc_misalign=1 and exc_addr=mem_addr for one cycle, wb_valid=0, stay IDLE.
- Undefined: low address bits forced to natural alignment (half clears bit 0, word clears bits 1:0) and access proceeds; exc_* tied 0.

## Test plan
- Pass-through: reg_w=1, rd=5, reg_data=0x12345678, 3 back-to-back -> wb_valid 3 consecutive cycles, wb_data 0x12345678, in_ready constantly 1.
- Store byte addr 0x1003, data 0xAABBCCDD, ack after 2 waits -> dmem_addr 0x1000, be 1000, wdata 0xDDDDDDDD held 3 cycles; wb_valid 1 cycle later with wb_reg_w=0.
- Load byte signed addr 0x2001, rdata 0x0000_8000 zero-wait -> wb_data 0xFFFFFF80; same with mem_uns=1 -> 0x00000080.
- Load half addr 0x2002, rdata 0x8001_0000 -> signed 0xFFFF8001, unsigned 0x00008001; be 0000, we 0.
- rst asserted mid-REQ with ack one cycle later -> dmem_req 0 after reset edge, no wb_valid, in_ready 1.
- Word load addr 0x3002: with macro -> exc_misalign pulse, exc_addr 0x3002, no dmem_req; without -> dmem_addr 0x3000, word result.
